// File: rtl/sdram_bus_arbiter.sv
// Round-robin arbiter for four masters sharing the SDRAM controller bus.
// Adds a begin-timeout on idle grants and a watchdog that aborts stalled transactions.
module sdram_bus_arbiter #(
  parameter int unsigned BEGIN_TIMEOUT   = 16,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sdramInitBusy,
  input  logic [3:0] request,
  input  logic       beginTransactionIn,
  input  logic       endTransactionIn,
  input  logic       dataValidIn,
  input  logic       busyIn,
  output logic [3:0] grant,
  output logic [1:0] activeMaster,
  output logic       busErrorOut,
  output logic       endTransactionOut,
  output logic       busIdle
);

  localparam int unsigned BT_W = 8;
  localparam int unsigned WD_W = 16;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_ACTIVE  = 2'd2,
    S_ABORT   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [BT_W-1:0] bcnt_q, bcnt_d;
  logic [WD_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      am_q, am_d;
  logic            err_q, err_d;
  logic            endo_q, endo_d;
  logic            idle_q, idle_d;
  logic [1:0]      win_c;
  logic [1:0]      idx_c;
  logic            found_c;

  // Round-robin search starting just after the last served master.
  always_comb begin
    win_c   = last_q;
    idx_c   = last_q;
    found_c = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx_c = last_q + 2'(i);
      if (!found_c && request[idx_c]) begin
        win_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      grant_q <= '0;
      am_q    <= '0;
      err_q   <= 1'b0;
      endo_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      grant_q <= grant_d;
      am_q    <= am_d;
      err_q   <= err_d;
      endo_q  <= endo_d;
      idle_q  <= idle_d;
    end
  end

  // During GRANTED/ACTIVE/ABORT last_q holds the current owner.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if ((request != 4'b0000) && !sdramInitBusy) begin
          state_d = S_GRANTED;
          last_d  = win_c;
          bcnt_d  = '0;
        end
      end
      S_GRANTED: begin
        if (beginTransactionIn) begin
          state_d = S_ACTIVE;
          wcnt_d  = '0;
        end else if (!request[last_q] || (bcnt_q >= BT_LAST)) begin
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q + BT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (endTransactionIn) begin
          state_d = S_IDLE;
        end else if (dataValidIn || busyIn) begin
          wcnt_d = '0;
        end else if (wcnt_q >= WD_LAST) begin
          state_d = S_ABORT;
        end else begin
          wcnt_d = wcnt_q + WD_W'(1);
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = 4'b0000;
    am_d    = 2'd0;
    err_d   = 1'b0;
    endo_d  = 1'b0;
    idle_d  = (state_d == S_IDLE);
    if (state_d != S_IDLE) begin
      grant_d = 4'b0001 << last_d;
      am_d    = last_d;
    end
    if (state_d == S_ABORT) begin
      err_d  = 1'b1;
      endo_d = 1'b1;
    end
  end

  assign grant             = grant_q;
  assign activeMaster      = am_q;
  assign busErrorOut       = err_q;
  assign endTransactionOut = endo_q;
  assign busIdle           = idle_q;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Bench for sdram_bus_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of ownership, begin wait and bus quiet time.
module tb_sdram_bus_arbiter;

  localparam int BT = 16;
  localparam int WD = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       sdramInitBusy;
  logic [3:0] request;
  logic       beginTransactionIn;
  logic       endTransactionIn;
  logic       dataValidIn;
  logic       busyIn;
  logic [3:0] grant;
  logic [1:0] activeMaster;
  logic       busErrorOut;
  logic       endTransactionOut;
  logic       busIdle;

  int total = 0;
  int bad   = 0;

  // model: who owns the bus, whether the transfer has begun, and how long it has waited/idled
  int m_owner = -1;
  bit m_xfer  = 1'b0;
  bit m_abort = 1'b0;
  int m_last  = 3;
  int m_wait  = 0;
  int m_quiet = 0;

  sdram_bus_arbiter #(.BEGIN_TIMEOUT(BT), .WATCHDOG_CYCLES(WD)) dut (
    .clock(clock), .reset(reset), .sdramInitBusy(sdramInitBusy), .request(request),
    .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busyIn(busyIn), .grant(grant),
    .activeMaster(activeMaster), .busErrorOut(busErrorOut),
    .endTransactionOut(endTransactionOut), .busIdle(busIdle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int pick;
    pick = -1;
    if (reset) begin
      m_owner = -1; m_xfer = 0; m_abort = 0; m_last = 3; m_wait = 0; m_quiet = 0;
    end else if (m_abort) begin
      m_abort = 0; m_owner = -1; m_xfer = 0;
    end else if (m_owner < 0) begin
      if (request != 4'b0000 && !sdramInitBusy) begin
        for (int k = 1; k <= 4; k++) begin
          int m;
          m = (m_last + k) % 4;
          if (pick < 0 && request[m]) pick = m;
        end
        m_owner = pick; m_last = pick; m_wait = 0; m_xfer = 0;
      end
    end else if (!m_xfer) begin
      if (beginTransactionIn) begin
        m_xfer = 1; m_quiet = 0;
      end else if (!request[m_owner] || m_wait + 1 >= BT) begin
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end else begin
      if (endTransactionIn) begin
        m_owner = -1; m_xfer = 0;
      end else if (dataValidIn || busyIn) begin
        m_quiet = 0;
      end else if (m_quiet + 1 >= WD) begin
        m_abort = 1;
      end else begin
        m_quiet++;
      end
    end
  endtask

  // One clock: model consumes the inputs the DUT will sample, then outputs are compared.
  task automatic tick();
    int eg;
    model_step();
    @(posedge clock);
    #1;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("model_grant", int'(grant), eg);
    chk("model_master", int'(activeMaster), (m_owner < 0) ? 0 : m_owner);
    chk("model_err", int'(busErrorOut), int'(m_abort));
    chk("model_endout", int'(endTransactionOut), int'(m_abort));
    chk("model_idle", int'(busIdle), (m_owner < 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    int k;
    int p_begin;
    reset = 1; sdramInitBusy = 0; request = 0; beginTransactionIn = 0;
    endTransactionIn = 0; dataValidIn = 0; busyIn = 0;
    tick(); tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_idle", int'(busIdle), 1);
    chk("rst_err", int'(busErrorOut), 0);
    reset = 0;

    // init busy blocks grants; release gives grant on the following edge
    sdramInitBusy = 1; request = 4'b0010;
    repeat (5) begin tick(); chk("init_hold", int'(grant), 0); end
    sdramInitBusy = 0;
    tick();
    chk("init_release", int'(grant), 2);
    chk("init_master", int'(activeMaster), 1);
    request = 0; tick();
    chk("req_drop", int'(grant), 0);

    // begin timeout: master 2 holds grant exactly BT cycles
    request = 4'b0100; tick();
    chk("bt_grant", int'(grant), 4);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("bt_noerr", int'(busErrorOut), 0);
      if (grant == 0) break;
      n++;
    end
    chk("bt_len", n, 16);
    request = 0; tick();

    // watchdog abort 8 cycles after begin
    request = 4'b0001; tick();
    chk("wd_grant", int'(grant), 1);
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); k++;
      if (busErrorOut) break;
    end
    chk("wd_delay", k, 8);
    chk("wd_endout", int'(endTransactionOut), 1);
    chk("wd_hold", int'(grant), 1);
    tick();
    chk("wd_release", int'(grant), 0);
    chk("wd_err_off", int'(busErrorOut), 0);
    request = 0;

    // end on the expiry cycle wins over abort
    request = 4'b0010; tick();
    chk("endwin_grant", int'(grant), 2);
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    repeat (7) tick();
    endTransactionIn = 1; tick(); endTransactionIn = 0;
    chk("endwin_err", int'(busErrorOut), 0);
    chk("endwin_grant0", int'(grant), 0);
    request = 0;

    // reset during ACTIVE
    request = 4'b0100; tick();
    beginTransactionIn = 1; tick(); beginTransactionIn = 0;
    dataValidIn = 1; tick(); tick();
    chk("rstact_pre", int'(grant), 4);
    reset = 1; tick();
    chk("rstact_grant", int'(grant), 0);
    chk("rstact_idle", int'(busIdle), 1);
    chk("rstact_err", int'(busErrorOut), 0);
    chk("rstact_end", int'(endTransactionOut), 0);
    reset = 0; dataValidIn = 0;

    // round robin 0,1,2,3,0 with an IDLE cycle between grants
    request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", int'(grant), 1 << (i % 4));
      beginTransactionIn = 1; tick(); beginTransactionIn = 0;
      dataValidIn = 1; tick(); tick();
      endTransactionIn = 1; dataValidIn = 0; tick(); endTransactionIn = 0;
      chk("rr_gap", int'(grant), 0);
      chk("rr_gap_idle", int'(busIdle), 1);
    end
    request = 0;

    // randomized traffic: frequent begins, then sparse begins to reach timeouts
    for (int ph = 0; ph < 2; ph++) begin
      p_begin = (ph == 0) ? 5 : 40;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(3, 0) == 0) request = 4'($urandom_range(15, 0));
        if ($urandom_range(9, 0) == 0) sdramInitBusy = ($urandom_range(3, 0) == 0);
        beginTransactionIn = ($urandom_range(p_begin - 1, 0) == 0);
        endTransactionIn   = ($urandom_range(7, 0) == 0);
        dataValidIn        = ($urandom_range(11, 0) == 0);
        busyIn             = ($urandom_range(11, 0) == 0);
        reset              = ($urandom_range(299, 0) == 0);
        tick();
        chk("onehot", int'($onehot0(grant)), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_bus_arbiter.md
SDRAM_BUS_ARBITER -- requirements
Module: sdram_bus_arbiter

Interface
REQ-001 SHALL have parameter BEGIN_TIMEOUT, default 16: cycles a granted master has to assert beginTransactionIn, range 2..255.
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 1024: idle-activity cycles before an open transaction is aborted, range 2..65535.
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sdramInitBusy, input, 1: SDRAM initialisation in progress; no grants while high.
REQ-006 SHALL have port request, input, 4: per-master bus request, level-sensitive.
REQ-007 SHALL have port beginTransactionIn, input, 1: shared-bus transaction start.
REQ-008 SHALL have port endTransactionIn, input, 1: shared-bus transaction end.
REQ-009 SHALL have port dataValidIn, input, 1: shared-bus data beat.
REQ-010 SHALL have port busyIn, input, 1: shared-bus slave busy.
REQ-011 SHALL have port grant, output, 4: one-hot grant, registered.
REQ-012 SHALL have port activeMaster, output, 2: index of granted master; 0 when none.
REQ-013 SHALL have port busErrorOut, output, 1: watchdog abort error pulse.
REQ-014 SHALL have port endTransactionOut, output, 1: watchdog-generated transaction end pulse.
REQ-015 SHALL have port busIdle, output, 1: high only in state IDLE.

Function
REQ-016 SHALL implement states IDLE, GRANTED, ACTIVE, ABORT.
REQ-017 IDLE: request!=0 and sdramInitBusy=0 -> GRANTED; grant set on the next edge (one-cycle request-to-grant latency).
REQ-018 SHALL select winner round-robin: search starts at (lastServed+1) mod 4, ascending with wrap; lastServed resets to 3, so master 0 wins first.
REQ-019 lastServed SHALL update to the winner when entering GRANTED.
REQ-020 GRANTED: beginTransactionIn=1 -> ACTIVE, watchdog counter cleared.
REQ-021 GRANTED: request[winner] drops, or BEGIN_TIMEOUT cycles without begin -> IDLE, grant cleared on that edge.
REQ-022 ACTIVE: endTransactionIn=1 -> IDLE, grant cleared on that edge; request ignored while ACTIVE (no pre-emption).
REQ-023 ACTIVE: watchdog counter SHALL clear on any cycle with dataValidIn or busyIn high, else increment.
REQ-024 ACTIVE: counter reaching WATCHDOG_CYCLES-1 without activity -> ABORT.
REQ-025 ABORT: busErrorOut=1 and endTransactionOut=1 for exactly one cycle, grant held; then IDLE, grant cleared.
REQ-026 endTransactionIn and watchdog expiry in the same cycle: endTransactionIn wins, no ABORT.
REQ-027 beginTransactionIn and request drop in the same GRANTED cycle: begin wins, -> ACTIVE.
REQ-028 Back-to-back: a new grant SHALL NOT be issued in the same cycle grant clears; minimum one IDLE cycle between grants.
REQ-029 sdramInitBusy rising while GRANTED or ACTIVE SHALL NOT affect the current grant.
REQ-030 beginTransactionIn, endTransactionIn, dataValidIn, busyIn SHALL be ignored in IDLE.
REQ-031 grant SHALL be zero or one-hot at all times; activeMaster SHALL equal the index of the set bit.
REQ-032 Counters SHALL saturate, never wrap.

Reset
REQ-033 With reset high at a clock edge: state IDLE, grant=0, activeMaster=0, busErrorOut=0, endTransactionOut=0, busIdle=1, counters 0, lastServed=3.
REQ-034 Reset mid-transaction SHALL drop grant on the same edge with no error or end pulse.

Verification
REQ-035 Reset, request=4'b1111 held, each master ends after begin+3 cycles -> grants 0,1,2,3,0 in order, one IDLE cycle between.
REQ-036 sdramInitBusy=1, request=4'b0010 -> grant=0 throughout; initBusy low at cycle N -> grant=4'b0010 at N+1.
REQ-037 Grant master 2, no begin for 16 cycles -> grant=0 after cycle 16, busErrorOut stays 0.
REQ-038 WATCHDOG_CYCLES=8, begin then no activity -> busErrorOut and endTransactionOut high together for one cycle at 8 cycles after begin, then grant=0.
REQ-039 endTransactionIn on the watchdog expiry cycle -> no busErrorOut, normal release.
REQ-040 Reset asserted during ACTIVE -> grant=0, busIdle=1 next edge, no pulses.
